// File: rtl/bram_fifo_pkg.sv
// Shared constants, pointer type and depth helper for the block-RAM FIFO.
package bram_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  // Read/write pointer for the default geometry: one extra MSB separates full from empty.
  typedef logic [ADDR_W_DEF:0] ptr_t;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple-dual-port RAM with registered read, coded so synthesis maps it to block RAM.
module sdp_bram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= din;
  end

  // The read register has no reset so it stays a plain BRAM output latch.
  always_ff @(posedge clk) begin
    if (re) dout <= mem_q[raddr];
  end

endmodule

// File: rtl/bram_fifo.sv
// Single-clock FIFO on an inferred SDP block RAM with count, thresholds and sticky error flags.
// Optional macro BRAM_FIFO_OUTREG_EN adds an output register stage (read latency 2).
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("bram_fifo: AF_LEVEL exceeds FIFO depth");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("bram_fifo: AE_LEVEL must be below FIFO depth");
  end

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic              wr_acc, rd_acc;
  logic              vld_p1_q;
  logic [DATA_W-1:0] ram_dout;

  always_comb begin
    wr_acc   = wr_en & ~full_q;
    rd_acc   = rd_en & ~empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + ONE_C : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ONE_C : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Flags are registered from count_d so they track count in the same cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      ovf_q    <= ovf_q | (wr_en & full_q);
      udf_q    <= udf_q | (rd_en & empty_q);
      vld_p1_q <= rd_acc;
    end
  end

  // Stage p0 -> p1: RAM access; requests during reset never touch the array.
  sdp_bram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~RST),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .din   (din),
    .re    (rd_acc & ~RST),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .dout  (ram_dout)
  );

`ifdef BRAM_FIFO_OUTREG_EN
  logic              vld_p2_q;
  logic [DATA_W-1:0] dout_p2_q;

  // Stage p1 -> p2: output register, loaded only for valid reads so dout holds otherwise.
  always_ff @(posedge clk) begin
    if (RST) begin
      vld_p2_q  <= 1'b0;
      dout_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) dout_p2_q <= ram_dout;
    end
  end

  assign dout       = dout_p2_q;
  assign dout_valid = vld_p2_q;
`else
  logic zero_q;

  // The RAM latch is not reset, so dout is forced to zero until the first read after reset.
  always_ff @(posedge clk) begin
    if (RST)         zero_q <= 1'b1;
    else if (rd_acc) zero_q <= 1'b0;
  end

  assign dout       = zero_q ? '0 : ram_dout;
  assign dout_valid = vld_p1_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_bram_fifo.sv
// Directed self-checking bench for bram_fifo (default 8x64, thresholds 60/4).
module tb_bram_fifo;

  localparam int DEPTH = 64;
  localparam int AF    = 60;
  localparam int AE    = 4;
`ifdef BRAM_FIFO_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [6:0] count;

  bram_fifo dut (
    .clk          (clk),
    .RST          (RST),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference queue model
  logic [7:0] mq[$];
  int         m_cnt = 0;
  bit         m_ovf = 0, m_udf = 0;
  bit         pv1 = 0, pv2 = 0;
  logic [7:0] pd1 = '0, pd2 = '0;
  logic [7:0] m_dout = '0;
  int         seq_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit w, input logic [7:0] d, input bit r);
    bit         wacc, racc, out_v;
    logic [7:0] rdat;
    RST = rst; wr_en = w; din = d; rd_en = r;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_cnt = 0; m_ovf = 0; m_udf = 0;
      pv1 = 0; pv2 = 0; m_dout = '0;
    end else begin
      wacc = w && (m_cnt < DEPTH);
      racc = r && (m_cnt > 0);
      if (w && !wacc) m_ovf = 1;
      if (r && !racc) m_udf = 1;
      rdat = '0;
      if (racc) rdat = mq.pop_front();
      if (wacc) mq.push_back(d);
      m_cnt = mq.size();
      pv2 = pv1; pd2 = pd1;
      pv1 = racc; pd1 = rdat;
      out_v = (LAT == 1) ? pv1 : pv2;
      if (out_v) m_dout = (LAT == 1) ? pd1 : pd2;
    end
    #1;
    out_v = rst ? 1'b0 : ((LAT == 1) ? pv1 : pv2);
    check("count",        count,        m_cnt);
    check("empty",        empty,        m_cnt == 0);
    check("full",         full,         m_cnt == DEPTH);
    check("almost_full",  almost_full,  m_cnt >= AF);
    check("almost_empty", almost_empty, m_cnt <= AE);
    check("overflow",     overflow,     m_ovf);
    check("underflow",    underflow,    m_udf);
    check("dout_valid",   dout_valid,   out_v);
    check("dout",         dout,         m_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
  endtask

  initial begin
    phase = "reset";
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    idle(2);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_count", count, 0);

    phase = "fill";
    for (int i = 0; i < 64; i++) begin
      cyc(0, 1, 8'(i), 0);
      if (i == 58) check("af_below", almost_full, 0);
      if (i == 59) check("af_at60", almost_full, 1);
    end
    check("full_at64", full, 1);
    check("count64", count, 64);
    cyc(0, 1, 8'hAA, 0);
    check("ovf_65th", overflow, 1);
    check("count_stays", count, 64);

    phase = "drain";
    seq_idx = 0;
    for (int i = 0; i < 64 + LAT; i++) begin
      if (i < 64) cyc(0, 0, 8'h00, 1);
      else        idle(1);
      if (dout_valid) begin
        check("drain_seq", dout, seq_idx);
        seq_idx++;
      end
    end
    check("drain_total", seq_idx, 64);
    check("drain_empty", empty, 1);
    cyc(0, 0, 8'h00, 1);
    idle(LAT);
    check("udf_extra", underflow, 1);
    check("no_valid", dout_valid, 0);

    phase = "rw_empty";
    cyc(0, 1, 8'h12, 1);
    check("rw_empty_cnt", count, 1);
    cyc(0, 0, 8'h00, 1);
    idle(LAT);

    phase = "wrap";
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 40; i++) cyc(0, 1, 8'(i) ^ 8'h55, 0);
      check("wrap_cnt40", count, 40);
      seq_idx = 0;
      for (int i = 0; i < 40 + LAT; i++) begin
        if (i < 40) cyc(0, 0, 8'h00, 1);
        else        idle(1);
        if (dout_valid) begin
          check("wrap_seq", dout, 8'(seq_idx) ^ 8'h55);
          seq_idx++;
        end
      end
      check("wrap_total", seq_idx, 40);
    end
    check("wrap_cnt0", count, 0);

    phase = "simul";
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 8'(i), 0);
    for (int i = 0; i < 100; i++) cyc(0, 1, 8'(32 + i), 1);
    check("simul_cnt32", count, 32);
    for (int i = 0; i < 32; i++) cyc(0, 1, 8'hC0 + 8'(i), 0);
    check("simul_full", full, 1);
    check("simul_no_ovf", overflow, 0);
    cyc(0, 1, 8'hEE, 1);
    check("full_rw_cnt", count, 63);
    check("full_rw_ovf", overflow, 1);
    idle(LAT);

    phase = "midrst";
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'hA0 + 8'(i), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1);
    cyc(1, 1, 8'h99, 1);
    check("midrst_cnt", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_dout", dout, 0);
    cyc(0, 1, 8'h77, 0);
    cyc(0, 0, 8'h00, 1);
    idle(LAT - 1);
    check("after_rst_valid", dout_valid, 1);
    check("after_rst_dout", dout, 8'h77);
    idle(2);
    check("after_rst_hold", dout, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_fifo.md
Name: bram_fifo

Overview:
- Parametrised single-clock FIFO built on an inferred simple-dual-port block RAM, with a write port and a read port in the same clock domain.
- Generalises the fixed 64-entry BRAM primitive usage: data width, depth and programmable almost-full/almost-empty thresholds are configurable.
- Adds occupancy count and sticky overflow/underflow flags.
- Sits between streaming producers and consumers in the fifo project; feeds the UART/VGA datapaths.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 6, address width; depth = 2**ADDR_W (64).
- AF_LEVEL, 60, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request.
- dout  out  DATA_W  read data, qualified by dout_valid.
- dout_valid  out  1  one-cycle pulse per accepted read.
- full  out  1  count == 2**ADDR_W.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (RST=1 at a clk edge):
  - wr_ptr=rd_ptr=0, count=0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - dout_valid=0, dout=0, overflow=0, underflow=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored data; a request in the reset cycle is ignored.
- Pointers are ADDR_W+1 bits wide.
  - The MSB disambiguates full from empty.
  - Pointers wrap naturally modulo 2**(ADDR_W+1).
  - RAM is addressed by the low ADDR_W bits.
- Write acceptance:
  - wr_acc = wr_en & ~full.
  - On wr_acc: RAM[wr_ptr] <= din, wr_ptr++.
- Read acceptance:
  - rd_acc = rd_en & ~empty.
  - On rd_acc: RAM read at rd_ptr, rd_ptr++.
  - dout is updated and dout_valid=1 on the following cycle (latency 1).
  - dout holds its last value when dout_valid=0.
- Count update:
  - wr_acc & ~rd_acc: count+1.
  - rd_acc & ~wr_acc: count-1.
  - Both or neither: unchanged.
- All flags are registered and derived from the next-state count, so they are correct in the same cycle count changes.
- Simultaneous read and write:
  - When empty: only the write is accepted; the read is rejected and underflow is set. No fall-through.
  - When full: only the read is accepted; the write is rejected and overflow is set.
  - Otherwise both are accepted.
- Read and write of the same address in one cycle cannot occur, because that requires empty, where the read is rejected.
- overflow and underflow stay set until RST.
- Parameter legality: AF_LEVEL <= 2**ADDR_W and AE_LEVEL < 2**ADDR_W; violation is an elaboration-time error.

Optional Feature:
- Macro BRAM_FIFO_OUTREG_EN.
- Defined:
  - An extra output pipeline register (BRAM DO_REG equivalent) is inserted after the RAM read.
  - Read latency becomes 2 cycles; dout_valid is delayed identically.
  - Back-to-back reads still sustain 1 word/cycle.
  - Reset clears the extra stage.
- Undefined: read latency is 1 cycle, no extra register.
- Flags and count timing are identical in both builds.

Decomposition:
- Package bram_fifo_pkg:
  - default DATA_W/ADDR_W constants.
  - a depth function (2**ADDR_W).
  - a ptr_t typedef (ADDR_W+1 bits).
- Sub-module sdp_bram:
  - Generic simple-dual-port RAM, parameters DATA_W/ADDR_W.
  - Ports clk, we, waddr, din, re, raddr, dout.
  - Registered read; written so synthesis infers block RAM.
- bram_fifo holds the pointers, count, flags and the optional output stage.

Test Plan:
- Reset then idle: after RST pulse -> empty=1, almost_empty=1, count=0, dout_valid=0, overflow=0, underflow=0.
- Fill: write 64 words 0x00..0x3F, no reads.
  - almost_full rises when count reaches 60.
  - full=1 after the 64th write.
  - 65th write (0xAA) -> overflow=1, count stays 64.
- Drain: read 64 times.
  - dout sequence 0x00..0x3F, each 1 cycle after rd_en (2 with BRAM_FIFO_OUTREG_EN).
  - empty=1 at end.
  - Extra read -> underflow=1, no dout_valid.
- Wrap-around: write 40, read 40, write 40, read 40 with data = index ^ 0x55 -> every word returned in order, count returns to 0, pointers wrapped.
- Simultaneous traffic: hold count at 32, then wr_en=rd_en=1 for 100 cycles -> count stays 32, output order preserved.
  - At full with both asserted: one read accepted, count=63, overflow=1.
- Reset mid-stream: reset after 10 writes and 3 reads -> count=0, empty=1.
  - A subsequent write of 0x77 then read -> dout=0x77.
